seg_count_scan_ctrl: RTL and testbench
======================================

// Module: seg_count_scan_ctrl
// PURPOSE
//  Sequencer between the button debouncers and a 4-digit common-anode 7-seg display.
//  Holds a 4-digit BCD event count (0000-9999) driven by debounced inc/dec/clr strobes.
//  Time-multiplexes the count onto the shared segment bus, one digit at a time.
//  Leading zeros are optionally blanked. Sits between the Debouncer instances and the board pins.
// PARAMETERS
//  SCAN_DIV  50000  clocks each digit stays lit; legal range 2..65535
//  BLANK_LZ  1      1 = blank leading zeros (digit 0 is never blanked); 0 = show all digits
// PORTS
//  clk        in   1   system clock, all logic on posedge
//  reset      in   1   asynchronous, active-low (0 = reset)
//  inc        in   1   debounced count-up strobe, sampled as a level every clock
//  dec        in   1   debounced count-down strobe, sampled as a level every clock
//  clr        in   1   synchronous clear of the count
//  count_bcd  out  16  current count; [3:0] = ones ... [15:12] = thousands
//  wrap       out  1   one-cycle pulse on 9999->0000 or 0000->9999
//  an         out  4   digit enables, active-low, one-hot-low; an[0] = ones digit
//  seg        out  7   segments {g,f,e,d,c,b,a}, active-low
//  dp         out  1   decimal point, active-low; held 1 (off)
// BEHAVIOUR
//  Reset (async assert on reset=0, release sync to clk):
//   count_bcd=16'h0000, wrap=0, scan prescaler=0, digit index=0,
//   an=4'b1110, seg=7'b1000000 (a "0"), dp=1.
//  Count update, priority clr > (inc^dec); registered, visible the clock after the strobe:
//   - clr=1: count=0000, wrap=0.
//   - inc=1 and dec=1 (and clr=0): no change, wrap=0.
//   - inc only: BCD +1 with digit carry (x9 -> (x+1)0); 9999 -> 0000 with wrap=1.
//   - dec only: BCD -1 with digit borrow; 0000 -> 9999 with wrap=1.
//   - Each high cycle is one event. Single-cycle pulses come from the Debouncer, so no edge detect here.
//   - Every BCD nibble stays within 0-9 at all times.
//  Scan FSM, states DIG0 -> DIG1 -> DIG2 -> DIG3 -> DIG0:
//   - Prescaler counts 0..SCAN_DIV-1. At terminal it reloads 0 and the FSM advances one state.
//   - The FSM never stalls. Count activity does not affect scan timing.
//  Output stage, registered every clock from the current state and the current count_bcd:
//   - an: low only for the active digit (DIG0 -> 4'b1110 ... DIG3 -> 4'b0111).
//   - seg: standard decode, 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001
//          5=0010010 6=0000010 7=1111000 8=0000000 9=0010000.
//   - Blank seg = 7'b1111111.
//   - Leading-zero blanking (BLANK_LZ=1): blank digit k>0 when nibble k and every higher nibble are 0.
//     Example: 0040 shows "  40"; 0000 shows "   0".
//   - Latency: count change -> seg change is 1 clock if that digit is active; otherwise it appears when the digit is next scanned (<= 4*SCAN_DIV clocks).
//   - an and seg change on the same edge, so no glitch mixes two digits.
//  Reset asserted mid-scan or mid-count: everything returns to reset values immediately.
//   After release, scanning restarts at DIG0 with a full SCAN_DIV period.
// TESTING (SCAN_DIV=4 for sim)
//  1 reset=0 then release; no strobes -> count 0000; an cycles 1110,1101,1011,0111 every 4 clks;
//    seg=1000000 on DIG0, 1111111 on DIG1-3.
//  2 Nine single-clock inc pulses, then a 10th -> count 0009 then 0010; wrap stays 0;
//    DIG1 seg=1111001, DIG0 seg=1000000.
//  3 Load 9999 via dec from 0000 -> wrap=1 for exactly 1 clk, count=9999; then inc -> 0000, wrap=1 for 1 clk.
//  4 inc=dec=1 for 3 clks at 0123 -> count stays 0123.
//    clr=inc=1 -> count 0000 the next clock.
//  5 BLANK_LZ=0, count 0040 -> DIG3/DIG2 show 1000000, DIG1 0011001, DIG0 1000000.
//  6 reset=0 asynchronously between clock edges while in DIG2 with count 0357 -> outputs take
//    reset values before the next edge; after release the first DIG0 dwell lasts 4 clks.

Source files
------------

// File: rtl/seg_count_scan_ctrl.sv
// rtl/seg_count_scan_ctrl.sv - 4-digit BCD event counter with multiplexed 7-seg scan
module seg_count_scan_ctrl #(
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    input  logic        dec,
    input  logic        clr,
    output logic [15:0] count_bcd,
    output logic        wrap,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } scan_state_t;

    localparam logic [15:0] PRESC_LAST = 16'(SCAN_DIV - 1);

    scan_state_t state;
    scan_state_t nxt_state;
    logic [15:0] presc;
    logic        presc_tc;
    logic [3:0]  sel_nib;
    logic        sel_blank;
    logic [3:1]  lz;
    logic [6:0]  nxt_seg;
    logic [3:0]  nxt_an;

    // BCD +1 with per-digit carry; 9999 rolls to 0000
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (v[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // BCD -1 with per-digit borrow; 0000 rolls to 9999
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (b) begin
                if (v[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = 4'd9;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Count register: clr wins, simultaneous inc+dec cancel, wrap pulses on rollover
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_bcd <= 16'h0000;
            wrap      <= 1'b0;
        end else if (clr) begin
            count_bcd <= 16'h0000;
            wrap      <= 1'b0;
        end else if (inc && !dec) begin
            count_bcd <= bcd_inc(count_bcd);
            wrap      <= (count_bcd == 16'h9999);
        end else if (dec && !inc) begin
            count_bcd <= bcd_dec(count_bcd);
            wrap      <= (count_bcd == 16'h0000);
        end else begin
            wrap      <= 1'b0;
        end
    end

    // Next scan digit and the segment pattern it will show; the output registers
    // load from the next state so an and seg switch on the same edge as the FSM
    always_comb begin
        presc_tc  = (presc == PRESC_LAST);
        nxt_state = state;
        if (presc_tc) begin
            nxt_state = scan_state_t'(state + 2'd1);
        end
        lz[3] = (count_bcd[15:12] == 4'd0);
        lz[2] = lz[3] && (count_bcd[11:8] == 4'd0);
        lz[1] = lz[2] && (count_bcd[7:4] == 4'd0);
        sel_nib   = count_bcd[3:0];
        sel_blank = 1'b0;
        nxt_an    = 4'b1110;
        case (nxt_state)
            DIG0: begin sel_nib = count_bcd[3:0];   sel_blank = 1'b0;  nxt_an = 4'b1110; end
            DIG1: begin sel_nib = count_bcd[7:4];   sel_blank = lz[1]; nxt_an = 4'b1101; end
            DIG2: begin sel_nib = count_bcd[11:8];  sel_blank = lz[2]; nxt_an = 4'b1011; end
            DIG3: begin sel_nib = count_bcd[15:12]; sel_blank = lz[3]; nxt_an = 4'b0111; end
            default: begin sel_nib = count_bcd[3:0]; sel_blank = 1'b0; nxt_an = 4'b1110; end
        endcase
        nxt_seg = (BLANK_LZ && sel_blank) ? 7'b1111111 : seg_decode(sel_nib);
    end

    // Scan FSM with prescaler and registered digit/segment outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= DIG0;
            presc <= 16'd0;
            an    <= 4'b1110;
            seg   <= 7'b1000000;
            dp    <= 1'b1;
        end else begin
            presc <= presc_tc ? 16'd0 : presc + 16'd1;
            state <= nxt_state;
            an    <= nxt_an;
            seg   <= nxt_seg;
            dp    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seg_count_scan_ctrl.sv
// tb/tb_seg_count_scan_ctrl.sv - directed scoreboard bench for seg_count_scan_ctrl
module tb_seg_count_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        inc, dec, clr;
    logic [15:0] count_bcd, count_nb;
    logic        wrap, wrap_nb;
    logic [3:0]  an, an_nb;
    logic [6:0]  seg, seg_nb;
    logic        dp, dp_nb;

    typedef struct packed {
        logic [15:0] cnt;
        logic        wrp;
    } exp_t;

    exp_t sb[$];
    int   model_cnt = 0;
    int   n_pass = 0;
    int   n_total = 0;

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] S0    = 7'b1000000;
    localparam logic [6:0] S1    = 7'b1111001;
    localparam logic [6:0] S4    = 7'b0011001;

    always #5 clk = ~clk;

    seg_count_scan_ctrl #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .reset(reset), .inc(inc), .dec(dec), .clr(clr),
        .count_bcd(count_bcd), .wrap(wrap), .an(an), .seg(seg), .dp(dp)
    );

    seg_count_scan_ctrl #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .inc(inc), .dec(dec), .clr(clr),
        .count_bcd(count_nb), .wrap(wrap_nb), .an(an_nb), .seg(seg_nb), .dp(dp_nb)
    );

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Drive one clock of strobes at the falling edge, predict, then compare after the edge
    task automatic step(input logic i, input logic d, input logic c);
        exp_t e;
        logic w;
        inc = i; dec = d; clr = c;
        w = 1'b0;
        if (c) model_cnt = 0;
        else if (i && !d) begin
            if (model_cnt == 9999) begin model_cnt = 0; w = 1'b1; end
            else model_cnt++;
        end else if (d && !i) begin
            if (model_cnt == 0) begin model_cnt = 9999; w = 1'b1; end
            else model_cnt--;
        end
        sb.push_back('{cnt: to_bcd(model_cnt), wrp: w});
        @(negedge clk);
        inc = 1'b0; dec = 1'b0; clr = 1'b0;
        e = sb.pop_front();
        chk("count_bcd", {16'd0, count_bcd}, {16'd0, e.cnt});
        chk("wrap", {31'd0, wrap}, {31'd0, e.wrp});
    endtask

    task automatic wait_an(input logic [3:0] tgt, input logic use_nb);
        for (int k = 0; k < 20; k++) begin
            if ((use_nb ? an_nb : an) == tgt) break;
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b0; inc = 1'b0; dec = 1'b0; clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_count", {16'd0, count_bcd}, 32'h0);
        chk("rst_an", {28'd0, an}, {28'd0, 4'b1110});
        chk("rst_seg", {25'd0, seg}, {25'd0, S0});
        chk("rst_dp", {31'd0, dp}, 32'd1);
        chk("rst_wrap", {31'd0, wrap}, 32'd0);

        // 1: free-running scan, digit k active for 4 clocks, only DIG0 lit
        reset = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            logic [3:0] ea;
            @(negedge clk);
            ea = ~(4'b0001 << ((j / 4) % 4));
            chk("scan_an", {28'd0, an}, {28'd0, ea});
            chk("scan_seg", {25'd0, seg}, {25'd0, (((j / 4) % 4) == 0) ? S0 : BLANK});
        end

        // 2: count up through a digit carry
        for (int j = 0; j < 10; j++) step(1'b1, 1'b0, 1'b0);
        wait_an(4'b1101, 1'b0);
        chk("t2_dig1_an", {28'd0, an}, {28'd0, 4'b1101});
        chk("t2_dig1_seg", {25'd0, seg}, {25'd0, S1});
        wait_an(4'b1110, 1'b0);
        chk("t2_dig0_seg", {25'd0, seg}, {25'd0, S0});

        // 3: underflow and overflow wrap pulses
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // 4: inc+dec cancel at 0123, then clr beats inc
        for (int j = 0; j < 123; j++) step(1'b1, 1'b0, 1'b0);
        for (int j = 0; j < 3; j++) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);

        // 5: 0040 with and without leading-zero blanking
        for (int j = 0; j < 40; j++) step(1'b1, 1'b0, 1'b0);
        wait_an(4'b0111, 1'b1);
        chk("t5_nb_dig3", {25'd0, seg_nb}, {25'd0, S0});
        chk("t5_lz_dig3", {25'd0, seg}, {25'd0, BLANK});
        wait_an(4'b1011, 1'b1);
        chk("t5_nb_dig2", {25'd0, seg_nb}, {25'd0, S0});
        chk("t5_lz_dig2", {25'd0, seg}, {25'd0, BLANK});
        wait_an(4'b1101, 1'b1);
        chk("t5_nb_dig1", {25'd0, seg_nb}, {25'd0, S4});
        chk("t5_lz_dig1", {25'd0, seg}, {25'd0, S4});
        wait_an(4'b1110, 1'b1);
        chk("t5_nb_dig0", {25'd0, seg_nb}, {25'd0, S0});
        chk("t5_nb_dp", {31'd0, dp_nb}, 32'd1);

        // 6: asynchronous reset in DIG2 at 0357, then a full first DIG0 dwell
        for (int j = 0; j < 317; j++) step(1'b1, 1'b0, 1'b0);
        wait_an(4'b1011, 1'b0);
        chk("t6_pre_an", {28'd0, an}, {28'd0, 4'b1011});
        #2 reset = 1'b0;
        #1;
        chk("t6_async_count", {16'd0, count_bcd}, 32'h0);
        chk("t6_async_an", {28'd0, an}, {28'd0, 4'b1110});
        chk("t6_async_seg", {25'd0, seg}, {25'd0, S0});
        chk("t6_async_dp", {31'd0, dp}, 32'd1);
        model_cnt = 0;
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            chk("t6_dwell_an", {28'd0, an}, {28'd0, (j < 4) ? 4'b1110 : 4'b1101});
        end
        step(1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
